// File: rtl/ejecutor_bus_rtc.sv
// ejecutor_bus_rtc
// Runs one transaction on the multiplexed address/data bus of an RTC for each
// request from the phase sequencer. Each transaction walks through four
// timed phases (address, pause, data, finish) of T_FASE cycles each, then
// pulses listo for one cycle and returns to idle.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous reset, active low
//   enable_inicio   request: init transaction (highest priority)
//   enable_escribir request: write transaction
//   enable_leer     request: read transaction (lowest priority)
//   posicion        register index within the current phase
//   dato_escribir   write data for escribir transactions
//   ad_in           bus value sampled during reads
//   ad_out          value driven onto the bus
//   ad_oe           1 = block drives the bus
//   cs_n/rd_n/wr_n  active-low chip select, read and write strobes
//   a_d             0 = address phase, 1 = data phase
//   dato_leido      last byte captured by a read
//   listo           one-cycle completion pulse
module ejecutor_bus_rtc #(
   parameter int T_FASE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_inicio,
   input  logic       enable_escribir,
   input  logic       enable_leer,
   input  logic [1:0] posicion,
   input  logic [7:0] dato_escribir,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic [7:0] dato_leido,
   output logic       listo
);

   typedef enum logic [2:0] {REPOSO, DIR, PAUSA, DATO, FIN, LISTO} estado_t;
   typedef enum logic [1:0] {M_INICIO = 2'd0, M_ESCRIBIR = 2'd1, M_LEER = 2'd2} modo_t;

   localparam logic [3:0] ULTIMO = 4'(T_FASE - 1);

   estado_t    estado, estado_sig;
   modo_t      modo, modo_sig;
   logic [3:0] cnt;
   logic [1:0] pos_lat;
   logic [7:0] dato_lat;
   logic       arrancar;
   logic       fin_fase;

   function automatic logic [7:0] direccion(input modo_t m, input logic [1:0] p);
      logic [7:0] d;
      if (m == M_INICIO) begin
         case (p)
            2'd0:    d = 8'h02;
            2'd1:    d = 8'h02;
            2'd2:    d = 8'h10;
            default: d = 8'hF0;
         endcase
      end else begin
         case (p)
            2'd0:    d = 8'h21;
            2'd1:    d = 8'h22;
            2'd2:    d = 8'h23;
            default: d = 8'hF0;
         endcase
      end
      return d;
   endfunction

   function automatic logic [7:0] dato_inicio(input logic [1:0] p);
      logic [7:0] d;
      case (p)
         2'd0:    d = 8'h10;
         2'd1:    d = 8'h00;
         2'd2:    d = 8'hD2;
         default: d = 8'hF0;
      endcase
      return d;
   endfunction

   assign fin_fase = (cnt == ULTIMO);
   assign modo_sig = enable_inicio   ? M_INICIO :
                     enable_escribir ? M_ESCRIBIR : M_LEER;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado <= REPOSO;
         cnt    <= '0;
      end else begin
         estado <= estado_sig;
         // The phase counter only runs inside the timed phases and restarts
         // on every state change.
         if (estado_sig != estado || estado == REPOSO || estado == LISTO)
            cnt <= '0;
         else
            cnt <= cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         modo       <= M_INICIO;
         pos_lat    <= '0;
         dato_lat   <= '0;
         dato_leido <= '0;
      end else begin
         // Everything the transaction needs is frozen on the start edge so
         // later changes on the request inputs cannot disturb it.
         if (arrancar) begin
            modo     <= modo_sig;
            pos_lat  <= posicion;
            dato_lat <= dato_escribir;
         end
         if (estado == DATO && modo == M_LEER && fin_fase)
            dato_leido <= ad_in;
      end
   end

   // LISTO always drops back to REPOSO, so enables are looked at only after
   // one idle cycle, by which time the sequencer has advanced posicion.
   always_comb begin
      estado_sig = estado;
      arrancar   = 1'b0;
      case (estado)
         REPOSO: if (enable_inicio || enable_escribir || enable_leer) begin
            estado_sig = DIR;
            arrancar   = 1'b1;
         end
         DIR:     if (fin_fase) estado_sig = PAUSA;
         PAUSA:   if (fin_fase) estado_sig = DATO;
         DATO:    if (fin_fase) estado_sig = FIN;
         FIN:     if (fin_fase) estado_sig = LISTO;
         LISTO:   estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   always_comb begin
      cs_n   = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      a_d    = 1'b1;
      ad_oe  = 1'b0;
      ad_out = 8'h00;
      listo  = 1'b0;
      case (estado)
         DIR: begin
            cs_n   = 1'b0;
            a_d    = 1'b0;
            wr_n   = 1'b0;
            ad_oe  = 1'b1;
            ad_out = direccion(modo, pos_lat);
         end
         PAUSA: begin
            cs_n   = 1'b0;
            a_d    = 1'b0;
            ad_oe  = 1'b1;
            ad_out = direccion(modo, pos_lat);
         end
         DATO: begin
            cs_n = 1'b0;
            if (modo == M_LEER) begin
               // Bus released while the RTC drives it.
               rd_n = 1'b0;
            end else begin
               wr_n   = 1'b0;
               ad_oe  = 1'b1;
               ad_out = (modo == M_INICIO) ? dato_inicio(pos_lat) : dato_lat;
            end
         end
         LISTO:   listo = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ejecutor_bus_rtc.sv
// tb_ejecutor_bus_rtc
// Drives two copies of ejecutor_bus_rtc (T_FASE=4 and T_FASE=1) from the same
// requests and compares every output, every cycle, against a transaction
// timeline model; directed scenarios add explicit checks on top.
module tb_ejecutor_bus_rtc;

   logic       clk, reset;
   logic       enable_inicio, enable_escribir, enable_leer;
   logic [1:0] posicion;
   logic [7:0] dato_escribir, ad_in;

   logic [7:0] o4_ad_out, o4_dato_leido, o1_ad_out, o1_dato_leido;
   logic       o4_ad_oe, o4_cs_n, o4_rd_n, o4_wr_n, o4_a_d, o4_listo;
   logic       o1_ad_oe, o1_cs_n, o1_rd_n, o1_wr_n, o1_a_d, o1_listo;

   int checks = 0;
   int errors = 0;

   ejecutor_bus_rtc #(.T_FASE(4)) u4 (
      .clk(clk), .reset(reset), .enable_inicio(enable_inicio),
      .enable_escribir(enable_escribir), .enable_leer(enable_leer),
      .posicion(posicion), .dato_escribir(dato_escribir), .ad_in(ad_in),
      .ad_out(o4_ad_out), .ad_oe(o4_ad_oe), .cs_n(o4_cs_n), .rd_n(o4_rd_n),
      .wr_n(o4_wr_n), .a_d(o4_a_d), .dato_leido(o4_dato_leido), .listo(o4_listo));

   ejecutor_bus_rtc #(.T_FASE(1)) u1 (
      .clk(clk), .reset(reset), .enable_inicio(enable_inicio),
      .enable_escribir(enable_escribir), .enable_leer(enable_leer),
      .posicion(posicion), .dato_escribir(dato_escribir), .ad_in(ad_in),
      .ad_out(o1_ad_out), .ad_oe(o1_ad_oe), .cs_n(o1_cs_n), .rd_n(o1_rd_n),
      .wr_n(o1_wr_n), .a_d(o1_a_d), .dato_leido(o1_dato_leido), .listo(o1_listo));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [21:0] obs4, obs1;
   assign obs4 = {o4_cs_n, o4_rd_n, o4_wr_n, o4_a_d, o4_ad_oe, o4_listo, o4_ad_out, o4_dato_leido};
   assign obs1 = {o1_cs_n, o1_rd_n, o1_wr_n, o1_a_d, o1_ad_oe, o1_listo, o1_ad_out, o1_dato_leido};

   localparam logic [21:0] IDLE = {6'b111100, 16'h0000};

   logic [7:0] DIR_INI [4] = '{8'h02, 8'h02, 8'h10, 8'hF0};
   logic [7:0] DAT_INI [4] = '{8'h10, 8'h00, 8'hD2, 8'hF0};
   logic [7:0] DIR_RW  [4] = '{8'h21, 8'h22, 8'h23, 8'hF0};
   int         TF      [2] = '{4, 1};

   task automatic revisar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Timeline model: a transaction is "active" for 4*T+1 cycles after its
   // start edge; k is the cycle index inside it, LISTO is k == 4*T.
   logic       activo [2];
   int         k      [2];
   int         modo_m [2];
   int         pos_m  [2];
   logic [7:0] dat_m  [2];
   logic [7:0] leido  [2];

   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            activo[i] <= 1'b0;
            k[i]      <= 0;
            modo_m[i] <= 0;
            pos_m[i]  <= 0;
            dat_m[i]  <= 8'h00;
            leido[i]  <= 8'h00;
         end else if (!activo[i]) begin
            if (enable_inicio || enable_escribir || enable_leer) begin
               activo[i] <= 1'b1;
               k[i]      <= 0;
               modo_m[i] <= enable_inicio ? 0 : (enable_escribir ? 1 : 2);
               pos_m[i]  <= int'(posicion);
               dat_m[i]  <= dato_escribir;
            end
         end else begin
            if (modo_m[i] == 2 && k[i] == 3 * TF[i] - 1) leido[i] <= ad_in;
            if (k[i] == 4 * TF[i]) activo[i] <= 1'b0;
            else k[i] <= k[i] + 1;
         end
      end
   end

   function automatic logic [21:0] esperado(input logic act, input int kk, input int t,
                                             input int md, input int ps,
                                             input logic [7:0] dt, input logic [7:0] ld);
      logic       cs, rd, wr, ad, oe, li;
      logic [7:0] dir, sal;
      int         fase;
      cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b1; oe = 1'b0; li = 1'b0; sal = 8'h00;
      dir = (md == 0) ? DIR_INI[ps] : DIR_RW[ps];
      if (act) begin
         fase = kk / t;
         if (kk == 4 * t) li = 1'b1;
         else if (fase == 0) begin cs = 1'b0; ad = 1'b0; wr = 1'b0; oe = 1'b1; sal = dir; end
         else if (fase == 1) begin cs = 1'b0; ad = 1'b0; oe = 1'b1; sal = dir; end
         else if (fase == 2) begin
            cs = 1'b0;
            if (md == 2) rd = 1'b0;
            else begin wr = 1'b0; oe = 1'b1; sal = (md == 0) ? DAT_INI[ps] : dt; end
         end
      end
      return {cs, rd, wr, ad, oe, li, sal, ld};
   endfunction

   logic cont4, cont1;
   int   lat4, lat1;

   always @(negedge clk) begin
      if (!reset) begin
         cont4 <= 1'b0;
         cont1 <= 1'b0;
      end else begin
         revisar("bus_t4", 32'(obs4),
                 32'(esperado(activo[0], k[0], TF[0], modo_m[0], pos_m[0], dat_m[0], leido[0])));
         revisar("bus_t1", 32'(obs1),
                 32'(esperado(activo[1], k[1], TF[1], modo_m[1], pos_m[1], dat_m[1], leido[1])));
         revisar("rdwr_overlap_t4", 32'(!o4_rd_n && !o4_wr_n), 32'd0);
         revisar("rdwr_overlap_t1", 32'(!o1_rd_n && !o1_wr_n), 32'd0);
         revisar("oe_on_read_t4", 32'(!o4_rd_n && o4_ad_oe), 32'd0);
         revisar("oe_on_read_t1", 32'(!o1_rd_n && o1_ad_oe), 32'd0);
         // Latency measured on the pins: first cs_n low cycle through the listo cycle.
         if (!cont4 && !o4_cs_n) begin cont4 <= 1'b1; lat4 <= 1; end
         else if (cont4) begin
            lat4 <= lat4 + 1;
            if (o4_listo) begin revisar("latency_t4", 32'(lat4 + 1), 32'd17); cont4 <= 1'b0; end
         end
         if (!cont1 && !o1_cs_n) begin cont1 <= 1'b1; lat1 <= 1; end
         else if (cont1) begin
            lat1 <= lat1 + 1;
            if (o1_listo) begin revisar("latency_t1", 32'(lat1 + 1), 32'd5); cont1 <= 1'b0; end
         end
      end
   end

   task automatic pedir(input logic ini, input logic esc, input logic lee,
                        input logic [1:0] p, input logic [7:0] d);
      @(negedge clk);
      enable_inicio   = ini;
      enable_escribir = esc;
      enable_leer     = lee;
      posicion        = p;
      dato_escribir   = d;
   endtask

   task automatic soltar();
      enable_inicio   = 1'b0;
      enable_escribir = 1'b0;
      enable_leer     = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      soltar();
      posicion = 2'd0; dato_escribir = 8'h00; ad_in = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      revisar("reset_t4", 32'(obs4), 32'(IDLE));
      revisar("reset_t1", 32'(obs1), 32'(IDLE));
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Init transaction, position 2.
      pedir(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) soltar();
         if (c <= 4) revisar("ini_dir", 32'(o4_ad_out), 32'h10);
         if (c >= 9 && c <= 12) revisar("ini_dato", 32'({o4_wr_n, o4_ad_out}), 32'h0D2);
         if (c == 16 || c == 17) revisar("ini_listo", 32'(o4_listo), 32'(c == 17));
      end

      // Read transaction, position 1, bus returns 0x59.
      ad_in = 8'h59;
      pedir(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) soltar();
         if (c == 1) revisar("lee_dir", 32'(o4_ad_out), 32'h22);
         if (c >= 9 && c <= 12) revisar("lee_strobe", 32'({o4_rd_n, o4_ad_oe}), 32'd0);
         if (c == 13) revisar("lee_dato", 32'(o4_dato_leido), 32'h59);
         if (c == 17) revisar("lee_listo", 32'(o4_listo), 32'd1);
      end

      // Write transaction whose inputs change mid-flight.
      pedir(1'b0, 1'b1, 1'b0, 2'd0, 8'h45);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) soltar();
         if (c == 5) begin dato_escribir = 8'h99; enable_leer = 1'b1; posicion = 2'd3; end
         if (c == 6) soltar();
         if (c == 1) revisar("esc_dir", 32'(o4_ad_out), 32'h21);
         if (c >= 9 && c <= 12) revisar("esc_dato", 32'({o4_wr_n, o4_ad_out}), 32'h045);
      end
      repeat (20) @(negedge clk);

      // All enables held: init wins, back-to-back with one idle cycle.
      pedir(1'b1, 1'b1, 1'b1, 2'd1, 8'h77);
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c == 1) revisar("prio_dir", 32'(o4_ad_out), 32'h02);
         if (c == 9) revisar("prio_dato", 32'({o4_wr_n, o4_ad_out}), 32'h000);
         if (c == 17) revisar("b2b_listo", 32'(o4_listo), 32'd1);
         if (c == 18) revisar("b2b_idle", 32'(o4_cs_n), 32'd1);
         if (c == 19) revisar("b2b_restart", 32'(o4_cs_n), 32'd0);
      end
      soltar();
      repeat (25) @(negedge clk);

      // Reset during the data phase of a write.
      pedir(1'b0, 1'b1, 1'b0, 2'd2, 8'hA5);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) soltar();
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      revisar("abort_t4", 32'(obs4), 32'(IDLE));
      revisar("abort_t1", 32'(obs1), 32'(IDLE));
      repeat (3) @(negedge clk);
      ad_in    = 8'h3C;
      reset    = 1'b1;
      enable_leer = 1'b1;
      posicion = 2'd3;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) soltar();
         if (c == 1) revisar("rst_lee_dir", 32'(o4_ad_out), 32'hF0);
         if (c == 13) revisar("rst_lee_dato", 32'(o4_dato_leido), 32'h3C);
         if (c == 17) revisar("rst_lee_listo", 32'(o4_listo), 32'd1);
      end

      // Random requests; the per-cycle monitor does the checking.
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         enable_inicio   = ($urandom_range(0, 5) == 0);
         enable_escribir = ($urandom_range(0, 3) == 0);
         enable_leer     = ($urandom_range(0, 2) == 0);
         posicion        = 2'($urandom_range(0, 3));
         dato_escribir   = 8'($urandom);
         ad_in           = 8'($urandom);
         if (n == 400) begin
            @(posedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      soltar();
      repeat (25) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
